// File: rtl/aud_trace_ctrl.sv
// aud_trace_ctrl: capture sequencer for the AUD branch-trace monitor.
// Pre-trigger / address-match / post-trigger capture into a circular RAM, then oldest-first readout.
//
// state | meaning
// IDLE  | waiting for arm, events ignored
// ARMED | pre-trigger capture, every event written, watching for address match
// POST  | post-trigger capture, remain counts down once per written event
// DONE  | RAM frozen, host pops entries oldest-first
module aud_trace_ctrl #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int CW    = 8
) (
  input  logic          aud_ck,
  input  logic          nrst,
  input  logic [31:0]   br_addr,
  input  logic          br_addr_vld,
  input  logic          br_oe,
  input  logic          buserror,
  input  logic          arm,
  input  logic          stop,
  input  logic [31:0]   trig_addr,
  input  logic [31:0]   trig_mask,
  input  logic [CW-1:0] post_count,
  input  logic          rd_en,
  output logic [32:0]   rd_data,
  output logic          rd_valid,
  output logic          rd_empty,
  output logic [1:0]    state,
  output logic          trig_hit,
  output logic          wrapped,
  output logic [AW:0]   fill,
  output logic [CW-1:0] err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [AW:0]   FILL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] REM_MAX   = AW'(DEPTH - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     fill_q, fill_d;
  logic [AW:0]     unread_q, unread_d;
  logic [AW-1:0]   remain_q, remain_d;
  logic            trig_hit_q, trig_hit_d;
  logic            wrapped_q, wrapped_d;
  logic            rd_valid_q, rd_valid_d;
  logic            rd_empty_q, rd_empty_d;
  logic [32:0]     rd_data_q, rd_data_d;
  logic [CW-1:0]   err_cnt_q, err_cnt_d;
  logic            err_prev_q, err_prev_d;

  logic [32:0]     trace_mem [DEPTH];
  logic            wr_en;
  logic            restart;
  logic            match;
  logic [31:0]     pc_ext;
  logic [AW-1:0]   post_clamp;

  assign match  = br_oe & br_addr_vld & (((br_addr ^ trig_addr) & trig_mask) == 32'd0);
  assign pc_ext = 32'(post_count);

  // Clamp keeps the trigger entry itself from being overwritten by post-trigger events.
  always_comb begin
    if (pc_ext > 32'(DEPTH - 1)) post_clamp = REM_MAX;
    else                         post_clamp = AW'(post_count);
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    unread_d   = unread_q;
    remain_d   = remain_q;
    trig_hit_d = trig_hit_q;
    wrapped_d  = wrapped_q;
    rd_empty_d = rd_empty_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    wr_en      = 1'b0;
    restart    = 1'b0;

    case (state_q)
      S_IDLE: restart = arm;
      S_ARMED: begin
        wr_en = br_oe;
        if (match) begin
          trig_hit_d = 1'b1;
          remain_d   = post_clamp;
          state_d    = (post_clamp == '0) ? S_DONE : S_POST;
        end
        if (stop) state_d = S_DONE;
      end
      S_POST: begin
        wr_en = br_oe;
        if (br_oe) begin
          remain_d = remain_q - AW'(1);
          if (remain_q == AW'(1)) state_d = S_DONE;
        end
        if (stop) state_d = S_DONE;
      end
      S_DONE: begin
        restart = arm;
        if (!arm && rd_en && !rd_empty_q) begin
          rd_data_d  = trace_mem[rd_ptr_q];
          rd_valid_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + AW'(1);
          unread_d   = unread_q - (AW+1)'(1);
          rd_empty_d = (unread_q == (AW+1)'(1));
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (restart) begin
      state_d    = S_ARMED;
      wr_ptr_d   = '0;
      fill_d     = '0;
      trig_hit_d = 1'b0;
      wrapped_d  = 1'b0;
      unread_d   = '0;
      rd_empty_d = 1'b1;
    end

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (fill_q == FILL_FULL) wrapped_d = 1'b1;
      else                     fill_d    = fill_q + (AW+1)'(1);
    end

    // Readout setup uses next-state values so an event in the closing cycle is included.
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      rd_ptr_d   = wrapped_d ? wr_ptr_d : '0;
      unread_d   = fill_d;
      rd_empty_d = (fill_d == '0);
    end
  end

  always_comb begin
    err_prev_d = buserror;
    err_cnt_d  = err_cnt_q;
    if (buserror && !err_prev_q && (err_cnt_q != {CW{1'b1}})) err_cnt_d = err_cnt_q + CW'(1);
  end

  always_ff @(posedge aud_ck or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      unread_q   <= '0;
      remain_q   <= '0;
      trig_hit_q <= 1'b0;
      wrapped_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_empty_q <= 1'b1;
      rd_data_q  <= '0;
      err_cnt_q  <= '0;
      err_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      unread_q   <= unread_d;
      remain_q   <= remain_d;
      trig_hit_q <= trig_hit_d;
      wrapped_q  <= wrapped_d;
      rd_valid_q <= rd_valid_d;
      rd_empty_q <= rd_empty_d;
      rd_data_q  <= rd_data_d;
      err_cnt_q  <= err_cnt_d;
      err_prev_q <= err_prev_d;
    end
  end

  always_ff @(posedge aud_ck) begin
    if (wr_en) trace_mem[wr_ptr_q] <= {br_addr_vld, br_addr};
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_empty = rd_empty_q;
  assign state    = state_q;
  assign trig_hit = trig_hit_q;
  assign wrapped  = wrapped_q;
  assign fill     = fill_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_aud_trace_ctrl.sv
// Bench for aud_trace_ctrl: queue-based capture model checked every cycle,
// directed scenarios with literal expectations, then a randomized run.
module tb_aud_trace_ctrl;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int CW    = 8;

  logic          aud_ck, nrst;
  logic [31:0]   br_addr;
  logic          br_addr_vld, br_oe, buserror, arm, stop, rd_en;
  logic [31:0]   trig_addr, trig_mask;
  logic [CW-1:0] post_count;
  logic [32:0]   rd_data;
  logic          rd_valid, rd_empty, trig_hit, wrapped;
  logic [1:0]    state;
  logic [AW:0]   fill;
  logic [CW-1:0] err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  aud_trace_ctrl #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
    .aud_ck(aud_ck), .nrst(nrst), .br_addr(br_addr), .br_addr_vld(br_addr_vld),
    .br_oe(br_oe), .buserror(buserror), .arm(arm), .stop(stop),
    .trig_addr(trig_addr), .trig_mask(trig_mask), .post_count(post_count),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .rd_empty(rd_empty),
    .state(state), .trig_hit(trig_hit), .wrapped(wrapped), .fill(fill), .err_cnt(err_cnt)
  );

  initial begin
    aud_ck = 1'b0;
    forever #5 aud_ck = ~aud_ck;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Model: cap holds the entries of the current capture (newest last, at most DEPTH);
  // rdq is the frozen copy being drained by the host.
  int          m_state   = 0;
  logic [32:0] cap[$];
  logic [32:0] rdq[$];
  bit          m_wrapped = 0;
  bit          m_trig    = 0;
  bit          m_rd_valid = 0;
  bit          m_prev_be = 0;
  logic [32:0] m_rd_data = '0;
  int          post_left = 0;
  int          m_err     = 0;
  int          m_nxt;
  bit          m_hit;

  function automatic void m_start();
    cap.delete();
    rdq.delete();
    m_wrapped = 0;
    m_trig    = 0;
  endfunction

  function automatic void m_write(input logic [32:0] e);
    cap.push_back(e);
    if (cap.size() > DEPTH) begin
      void'(cap.pop_front());
      m_wrapped = 1;
    end
  endfunction

  always @(posedge aud_ck or negedge nrst) begin
    if (!nrst) begin
      m_state = 0; m_start(); m_rd_valid = 0; m_rd_data = '0;
      post_left = 0; m_err = 0; m_prev_be = 0;
    end else begin
      m_hit = br_oe && br_addr_vld && (((br_addr ^ trig_addr) & trig_mask) == 32'd0);
      m_nxt = m_state;
      m_rd_valid = 0;
      if (buserror && !m_prev_be && m_err < 255) m_err++;
      m_prev_be = buserror;
      case (m_state)
        0: if (arm) begin m_start(); m_nxt = 1; end
        1: begin
          if (br_oe) m_write({br_addr_vld, br_addr});
          if (m_hit) begin
            m_trig = 1;
            post_left = (int'(post_count) > DEPTH - 1) ? DEPTH - 1 : int'(post_count);
            m_nxt = (post_left == 0) ? 3 : 2;
          end
          if (stop) m_nxt = 3;
        end
        2: begin
          if (br_oe) begin
            m_write({br_addr_vld, br_addr});
            post_left--;
            if (post_left == 0) m_nxt = 3;
          end
          if (stop) m_nxt = 3;
        end
        default: begin
          if (arm) begin m_start(); m_nxt = 1; end
          else if (rd_en && rdq.size() > 0) begin
            m_rd_valid = 1;
            m_rd_data  = rdq.pop_front();
          end
        end
      endcase
      if (m_nxt == 3 && m_state != 3) rdq = cap;
      m_state = m_nxt;
    end
  end

  always @(negedge aud_ck) begin
    chk("state", 64'(state), 64'(m_state));
    chk("trig_hit", 64'(trig_hit), 64'(m_trig));
    chk("wrapped", 64'(wrapped), 64'(m_wrapped));
    chk("fill", 64'(fill), 64'(cap.size()));
    chk("err_cnt", 64'(err_cnt), 64'(m_err));
    chk("rd_empty", 64'(rd_empty), (m_state == 3) ? 64'(rdq.size() == 0) : 64'd1);
    chk("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
    chk("rd_data", 64'(rd_data), 64'(m_rd_data));
  end

  task automatic tick();
    @(posedge aud_ck);
    #2;
  endtask

  task automatic send(input logic [31:0] a, input logic v);
    br_oe = 1'b1; br_addr = a; br_addr_vld = v;
    tick();
    br_oe = 1'b0; br_addr_vld = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic pop_expect(input string nm, input logic [32:0] exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk({nm, "_vld"}, 64'(rd_valid), 64'd1);
    chk(nm, 64'(rd_data), 64'(exp));
  endtask

  initial begin
    nrst = 1'b0; br_addr = '0; br_addr_vld = 1'b0; br_oe = 1'b0; buserror = 1'b0;
    arm = 1'b0; stop = 1'b0; trig_addr = '0; trig_mask = '0; post_count = '0; rd_en = 1'b0;
    repeat (2) tick();
    nrst = 1'b1;
    tick();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_fill", 64'(fill), 64'd0);
    chk("rst_empty", 64'(rd_empty), 64'd1);
    chk("rst_rd_data", 64'(rd_data), 64'd0);

    // 1: mask 0 triggers on the first valid event, three post entries
    trig_mask = '0; post_count = 8'd3;
    pulse_arm();
    chk("t1_armed", 64'(state), 64'd1);
    for (int i = 0; i < 5; i++) send(32'h100 + 32'(i), 1'b1);
    chk("t1_done", 64'(state), 64'd3);
    chk("t1_fill", 64'(fill), 64'd4);
    chk("t1_trig", 64'(trig_hit), 64'd1);
    for (int i = 0; i < 4; i++) pop_expect("t1_rd", {1'b1, 32'h100 + 32'(i)});
    chk("t1_empty", 64'(rd_empty), 64'd1);

    // 2: 300 misses, trigger, 10 post -> wrap, oldest kept is event #56
    trig_addr = 32'hDEAD0000; trig_mask = '1; post_count = 8'd10;
    pulse_arm();
    chk("t2_fill0", 64'(fill), 64'd0);
    for (int i = 1; i <= 300; i++) send(32'(i), 1'b1);
    chk("t2_no_trig", 64'(trig_hit), 64'd0);
    send(32'hDEAD0000, 1'b1);
    chk("t2_post", 64'(state), 64'd2);
    for (int j = 1; j <= 10; j++) send(32'h1000 + 32'(j), 1'b1);
    chk("t2_done", 64'(state), 64'd3);
    chk("t2_wrapped", 64'(wrapped), 64'd1);
    chk("t2_fill", 64'(fill), 64'd256);
    pop_expect("t2_first", {1'b1, 32'd56});
    rd_en = 1'b1;
    repeat (254) tick();
    rd_en = 1'b0;
    pop_expect("t2_last", {1'b1, 32'h100A});
    chk("t2_empty", 64'(rd_empty), 64'd1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("t2_pop_empty", 64'(rd_valid), 64'd0);

    // 3: matching address with vld=0 stored but does not trigger
    pulse_arm();
    send(32'hDEAD0000, 1'b0);
    chk("t3_no_trig", 64'(trig_hit), 64'd0);
    chk("t3_armed", 64'(state), 64'd1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("t3_done", 64'(state), 64'd3);
    pop_expect("t3_rd", {1'b0, 32'hDEAD0000});

    // 4: stop coincident with event
    pulse_arm();
    br_oe = 1'b1; br_addr = 32'h55; br_addr_vld = 1'b1; stop = 1'b1;
    tick();
    br_oe = 1'b0; br_addr_vld = 1'b0; stop = 1'b0;
    chk("t4_done", 64'(state), 64'd3);
    chk("t4_trig", 64'(trig_hit), 64'd0);
    chk("t4_fill", 64'(fill), 64'd1);
    pop_expect("t4_rd", {1'b1, 32'h55});

    // 5: post_count = DEPTH-1 keeps the trigger entry as the oldest word
    trig_mask = '0; post_count = 8'd255;
    pulse_arm();
    send(32'h5000, 1'b1);
    chk("t5_post", 64'(state), 64'd2);
    for (int j = 1; j <= 254; j++) send(32'h6000 + 32'(j), 1'b1);
    chk("t5_still_post", 64'(state), 64'd2);
    send(32'h60FF, 1'b1);
    chk("t5_done", 64'(state), 64'd3);
    chk("t5_fill", 64'(fill), 64'd256);
    chk("t5_wrapped", 64'(wrapped), 64'd0);
    pop_expect("t5_first", {1'b1, 32'h5000});

    // 6: reset mid-POST, then buserror edge counting and saturation
    post_count = 8'd20;
    pulse_arm();
    for (int j = 0; j < 4; j++) send(32'h7000 + 32'(j), 1'b1);
    chk("t6_post", 64'(state), 64'd2);
    nrst = 1'b0; tick();
    chk("t6_rst_state", 64'(state), 64'd0);
    chk("t6_rst_fill", 64'(fill), 64'd0);
    chk("t6_rst_empty", 64'(rd_empty), 64'd1);
    nrst = 1'b1; tick();
    for (int j = 0; j < 3; j++) begin buserror = 1'b1; tick(); buserror = 1'b0; tick(); end
    chk("t6_err3", 64'(err_cnt), 64'd3);
    for (int j = 0; j < 260; j++) begin buserror = 1'b1; tick(); buserror = 1'b0; tick(); end
    chk("t6_err_sat", 64'(err_cnt), 64'd255);

    // randomized run
    for (int c = 0; c < 6000; c++) begin
      if (c % 500 == 0) begin
        trig_addr = {28'hABCD000, 4'($urandom_range(0, 15))};
        case ($urandom_range(0, 3))
          0: trig_mask = '1;
          1: trig_mask = 32'hFFFFFFF0;
          2: begin trig_addr = 32'h12345678; trig_mask = '1; end
          default: trig_mask = 32'hFFFFFFFC;
        endcase
        post_count = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 40));
      end
      br_oe       = ($urandom_range(0, 99) < 50);
      br_addr     = {28'hABCD000, 4'($urandom_range(0, 15))};
      br_addr_vld = ($urandom_range(0, 9) < 8);
      arm         = ($urandom_range(0, 99) < 2);
      stop        = ($urandom_range(0, 999) < 2);
      rd_en       = ($urandom_range(0, 1) == 1);
      buserror    = ($urandom_range(0, 9) < 3);
      if (c == 3100) nrst = 1'b0;
      if (c == 3102) nrst = 1'b1;
      tick();
    end
    br_oe = 1'b0; arm = 1'b0; stop = 1'b0; rd_en = 1'b0; buserror = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
